// File: rtl/me_block_sequencer.sv
// Batch sequencer and show-ahead result FIFO for the full-search motion-estimation core.
// Optional ME_STATS_EN adds BestDist sum/min statistics; without it stat_sum/stat_min read 0.
module me_block_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DIST_W  = 8,
  parameter int MV_W    = 4,
  parameter int IDX_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic [IDX_W-1:0]              num_blocks,
  output logic                          me_start,
  input  logic                          me_completed,
  input  logic [DIST_W-1:0]             me_best_dist,
  input  logic [MV_W-1:0]               me_motion_x,
  input  logic [MV_W-1:0]               me_motion_y,
  output logic [IDX_W-1:0]              block_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W+DIST_W+2*MV_W-1:0] out_data,
  output logic                          busy,
  output logic                          batch_done,
  output logic [15:0]                   stat_sum,
  output logic [DIST_W-1:0]             stat_min,
  output logic [2:0]                    state_dbg
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CAP_W  = DIST_W + 2*MV_W;
  localparam int DATA_W = IDX_W + CAP_W;
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PTR_W:0] FILL_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   count_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               armed;
  logic [CAP_W-1:0]   cap_q;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fill;
  logic               full;
  logic               push;
  logic               pop;

  assign state_dbg = state;
  assign full      = (fill == FILL_MAX);
  assign push      = (state == CAPT);
  // Output stream: a word transfers on a cycle where out_valid && out_ready;
  // out_data holds the FIFO head and stays put while out_valid && !out_ready.
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      me_start   <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      block_idx  <= '0;
      count_q    <= '0;
      gap_cnt    <= '0;
      armed      <= 1'b0;
      cap_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          batch_done <= 1'b0;
          if (run) begin
            count_q   <= num_blocks;
            block_idx <= '0;
            busy      <= 1'b1;
            gap_cnt   <= '0;
            if (num_blocks == '0) begin
              state      <= DONE;
              batch_done <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // After the low gap, wait for a free FIFO slot so CAPT can never overflow it.
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (!full) begin
            state    <= RUN;
            me_start <= 1'b1;
            armed    <= 1'b0;
          end
        end
        RUN: begin
          // The first RUN cycle may still see completed left over from the last block.
          armed <= 1'b1;
          if (armed && me_completed) begin
            cap_q    <= {me_best_dist, me_motion_x, me_motion_y};
            me_start <= 1'b0;
            state    <= CAPT;
          end
        end
        CAPT: begin
          if (block_idx == count_q - IDX_W'(1)) begin
            state      <= DONE;
            batch_done <= 1'b1;
          end else begin
            block_idx <= block_idx + 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        DONE: begin
          batch_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          me_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {block_idx, cap_q};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

`ifdef ME_STATS_EN
  logic [15:0]       sum_q;
  logic [DIST_W-1:0] min_q;
  logic [DIST_W-1:0] cap_dist;
  logic [16:0]       sum_ext;

  assign cap_dist = cap_q[CAP_W-1 -: DIST_W];
  assign sum_ext  = {1'b0, sum_q} + 17'(cap_dist);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      min_q <= '1;
    end else if (state == IDLE && run) begin
      sum_q <= '0;
      min_q <= '1;
    end else if (state == CAPT) begin
      sum_q <= sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
      if (cap_dist < min_q) min_q <= cap_dist;
    end
  end

  assign stat_sum = sum_q;
  assign stat_min = min_q;
`else
  assign stat_sum = '0;
  assign stat_min = '0;
`endif

endmodule

// File: tb/tb_me_block_sequencer.sv
// Bench for me_block_sequencer: behavioural core model, result scoreboard, scenario tasks.
module tb_me_block_sequencer;

  localparam int DEPTH   = 4;
  localparam int DIST_W  = 8;
  localparam int MV_W    = 4;
  localparam int IDX_W   = 8;
  localparam int GAP_CYC = 2;
  localparam int DATA_W  = IDX_W + DIST_W + 2*MV_W;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              run = 1'b0;
  logic [IDX_W-1:0]  num_blocks = '0;
  logic              me_start;
  logic              me_completed = 1'b0;
  logic [DIST_W-1:0] me_best_dist = '0;
  logic [MV_W-1:0]   me_motion_x = '0;
  logic [MV_W-1:0]   me_motion_y = '0;
  logic [IDX_W-1:0]  block_idx;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              batch_done;
  logic [15:0]       stat_sum;
  logic [DIST_W-1:0] stat_min;
  logic [2:0]        state_dbg;

  me_block_sequencer #(
    .DEPTH(DEPTH), .DIST_W(DIST_W), .MV_W(MV_W), .IDX_W(IDX_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .num_blocks(num_blocks),
    .me_start(me_start), .me_completed(me_completed), .me_best_dist(me_best_dist),
    .me_motion_x(me_motion_x), .me_motion_y(me_motion_y), .block_idx(block_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .batch_done(batch_done), .stat_sum(stat_sum), .stat_min(stat_min), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_exp;
  logic [DATA_W-1:0] prev_data = '0;
  bit   hold_prev = 1'b0;

  logic [DIST_W-1:0] dist_tbl [0:15];
  logic [MV_W-1:0]   mx_tbl   [0:15];
  logic [MV_W-1:0]   my_tbl   [0:15];

  bit stale_mode = 1'b0;
  bit lat_arm    = 1'b0;
  bit prev_start = 1'b0;
  int sc = 0;
  int cyc = 0;
  int comp_cyc = 0;
  int valid_cyc = 0;
  int start_cnt = 0;
  int low_cnt = 0;
  int low_before = 0;
  int done_cnt = 0;
  int pop_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor/scoreboard first, then the core model, all on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got %h, expected no output", out_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (out_data !== sb_exp) $display("FAIL sb_data: got %h, expected %h", out_data, sb_exp);
          else n_pass++;
        end
        pop_cnt++;
      end
      if (hold_prev && out_valid) begin
        n_checks++;
        if (out_data !== prev_data) $display("FAIL sb_stable: got %h, expected held %h", out_data, prev_data);
        else n_pass++;
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && lat_arm) begin
        valid_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (batch_done) done_cnt++;
      if (me_start && !prev_start) begin
        start_cnt++;
        low_before = low_cnt;
      end
      if (me_start) low_cnt = 0;
      else if (busy) low_cnt++;
      else low_cnt = 0;
      prev_start = me_start;
    end else begin
      hold_prev = 1'b0;
      prev_start = 1'b0;
      low_cnt = 0;
    end

    if (!reset_n) begin
      me_completed = 1'b0;
      sc = 0;
    end else if (!me_start) begin
      sc = 0;
      if (!stale_mode) me_completed = 1'b0;
    end else begin
      sc++;
      if (sc == 2) begin
        me_completed = 1'b1;
        me_best_dist = dist_tbl[block_idx[3:0]];
        me_motion_x  = mx_tbl[block_idx[3:0]];
        me_motion_y  = my_tbl[block_idx[3:0]];
        comp_cyc     = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  task automatic pulse_run(input logic [IDX_W-1:0] n);
    num_blocks = n;
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'(i), dist_tbl[i], mx_tbl[i], my_tbl[i]});
  endtask

  task automatic wait_end(input string name, input int d0, input int budget);
    int i;
    i = 0;
    while (i < budget && !(done_cnt > d0 && !busy && !out_valid)) begin
      tick(1);
      i++;
    end
    n_checks++;
    if (i >= budget)
      $display("FAIL %s_timeout: busy=%b out_valid=%b pulses=%0d, expected idle and drained in %0d cycles",
               name, busy, out_valid, done_cnt - d0, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (me_start !== 1'b0) $display("FAIL reset_me_start: got %b, expected 0", me_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (batch_done !== 1'b0) $display("FAIL reset_batch_done: got %b, expected 0", batch_done); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h, expected 0", out_data); else n_pass++;
    n_checks++; if (block_idx !== '0) $display("FAIL reset_block_idx: got %h, expected 0", block_idx); else n_pass++;
    n_checks++; if (state_dbg !== S_IDLE) $display("FAIL reset_state: got %0d, expected %0d", state_dbg, S_IDLE); else n_pass++;
    n_checks++; if (stat_sum !== 16'h0) $display("FAIL reset_stat_sum: got %h, expected 0", stat_sum); else n_pass++;
`ifdef ME_STATS_EN
    n_checks++; if (stat_min !== 8'hFF) $display("FAIL reset_stat_min: got %h, expected ff", stat_min); else n_pass++;
`else
    n_checks++; if (stat_min !== 8'h00) $display("FAIL reset_stat_min: got %h, expected 00", stat_min); else n_pass++;
`endif
    reset_n = 1'b1;
    tick(2);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b, expected 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    int s0, d0, p0;
    dist_tbl[0] = 8'h12; mx_tbl[0] = 4'h3; my_tbl[0] = 4'hE;
    out_ready = 1'b1;
    s0 = start_cnt; d0 = done_cnt; p0 = pop_cnt;
    lat_arm = 1'b1;
    exp_q.push_back(24'h00123E);
    pulse_run(8'd1);
    wait_end("single", d0, 40);
    n_checks++; if (start_cnt - s0 !== 1) $display("FAIL single_starts: got %0d, expected 1", start_cnt - s0); else n_pass++;
    n_checks++; if (low_before !== GAP_CYC) $display("FAIL single_gap: got %0d, expected %0d", low_before, GAP_CYC); else n_pass++;
    n_checks++; if (valid_cyc - comp_cyc !== 2) $display("FAIL single_latency: got %0d, expected 2", valid_cyc - comp_cyc); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL single_done_pulse: got %0d, expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 1) $display("FAIL single_outputs: got %0d, expected 1", pop_cnt - p0); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL single_leftover: got %0d, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int s0, d0, p0;
    for (int i = 0; i < 6; i++) begin
      dist_tbl[i] = 8'(16*i + 5); mx_tbl[i] = 4'(i + 1); my_tbl[i] = 4'(15 - i);
    end
    out_ready = 1'b0;
    s0 = start_cnt; d0 = done_cnt; p0 = pop_cnt;
    push_exp(6);
    pulse_run(8'd6);
    tick(40);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b, expected 1", out_valid); else n_pass++;
    n_checks++; if (me_start !== 1'b0) $display("FAIL bp_start: got %b, expected 0", me_start); else n_pass++;
    n_checks++; if (state_dbg !== S_GAP) $display("FAIL bp_state: got %0d, expected %0d", state_dbg, S_GAP); else n_pass++;
    n_checks++; if (block_idx !== 8'd4) $display("FAIL bp_idx: got %0d, expected 4", block_idx); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 4) $display("FAIL bp_starts: got %0d, expected 4", start_cnt - s0); else n_pass++;
    out_ready = 1'b1;
    wait_end("bp", d0, 100);
    n_checks++; if (pop_cnt - p0 !== 6) $display("FAIL bp_outputs: got %0d, expected 6", pop_cnt - p0); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_leftover: got %0d, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_zero();
    int s0, d0;
    bit found;
    out_ready = 1'b1;
    s0 = start_cnt; d0 = done_cnt;
    found = 1'b0;
    num_blocks = 8'd0;
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      run = 1'b0;
      if (batch_done) found = 1'b1;
    end
    tick(3);
    n_checks++; if (found !== 1'b1) $display("FAIL zero_done: got %b, expected pulse within 2 cycles", found); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL zero_done_count: got %0d, expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 0) $display("FAIL zero_starts: got %0d, expected 0", start_cnt - s0); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL zero_valid: got %b, expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b, expected 0", busy); else n_pass++;
  endtask

  task automatic test_rerun();
    int s0, d0, p0;
    for (int i = 0; i < 3; i++) begin
      dist_tbl[i] = 8'(40 + 3*i); mx_tbl[i] = 4'(8 + i); my_tbl[i] = 4'(i);
    end
    out_ready = 1'b1;
    s0 = start_cnt; d0 = done_cnt; p0 = pop_cnt;
    push_exp(3);
    pulse_run(8'd3);
    for (int k = 0; k < 5; k++) begin
      tick(2);
      if (!busy) break;
      num_blocks = 8'd5;
      run = 1'b1;
      tick(1);
      run = 1'b0;
    end
    wait_end("rerun", d0, 80);
    n_checks++; if (pop_cnt - p0 !== 3) $display("FAIL rerun_outputs: got %0d, expected 3", pop_cnt - p0); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 3) $display("FAIL rerun_starts: got %0d, expected 3", start_cnt - s0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL rerun_done: got %0d, expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rerun_leftover: got %0d, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0, p0;
    bit found;
    for (int i = 0; i < 4; i++) begin
      dist_tbl[i] = 8'(100 + i); mx_tbl[i] = 4'(i); my_tbl[i] = 4'(7 - i);
    end
    out_ready = 1'b0;
    pulse_run(8'd4);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (block_idx == 8'd2 && me_start && state_dbg == S_RUN) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rmid_reach_run: got %b, expected block 2 in RUN", found); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (me_start !== 1'b0) $display("FAIL rmid_start: got %b, expected 0", me_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b, expected 0", out_valid); else n_pass++;
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    dist_tbl[0] = 8'hA5; mx_tbl[0] = 4'h9; my_tbl[0] = 4'h6;
    out_ready = 1'b1;
    d0 = done_cnt; p0 = pop_cnt;
    push_exp(1);
    pulse_run(8'd1);
    wait_end("rmid", d0, 40);
    n_checks++; if (pop_cnt - p0 !== 1) $display("FAIL rmid_outputs: got %0d, expected 1", pop_cnt - p0); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rmid_leftover: got %0d, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stats();
    int d0;
    logic [15:0] exp_sum;
    logic [7:0]  exp_min;
    dist_tbl[0] = 8'd200; dist_tbl[1] = 8'd100; dist_tbl[2] = 8'd250;
    for (int i = 0; i < 3; i++) begin
      mx_tbl[i] = 4'(3*i + 1); my_tbl[i] = 4'(12 - i);
    end
`ifdef ME_STATS_EN
    exp_sum = 16'd550; exp_min = 8'd100;
`else
    exp_sum = 16'd0; exp_min = 8'd0;
`endif
    stale_mode = 1'b1;
    out_ready = 1'b1;
    d0 = done_cnt;
    push_exp(3);
    pulse_run(8'd3);
    wait_end("stats", d0, 80);
    stale_mode = 1'b0;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL stats_leftover: got %0d, expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (stat_sum !== exp_sum) $display("FAIL stats_sum: got %0d, expected %0d", stat_sum, exp_sum); else n_pass++;
    n_checks++; if (stat_min !== exp_min) $display("FAIL stats_min: got %0d, expected %0d", stat_min, exp_min); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_zero();
    test_rerun();
    test_reset_mid();
    test_stats();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/me_block_sequencer.md
Name: me_block_sequencer

Overview:
- Downstream controller and result buffer for the full-search motion-estimation core (`top`).
- Drives the core's `start`, indexes successive macroblocks, and captures BestDist/motionX/motionY on each `completed`.
- Queues each result in a show-ahead FIFO and presents it on a valid/ready stream to the frame-level consumer.
- Runs a batch of `num_blocks` macroblocks per `run` request.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- DIST_W, 8, width of BestDist
- MV_W, 4, width of motionX/motionY (two's complement)
- IDX_W, 8, width of block index / batch count
- GAP_CYC, 2, cycles `me_start` is held low between runs

Ports:
- clock  in  1  rising-edge clock (same clock as the core)
- reset_n  in  1  asynchronous active-low reset
- run  in  1  single-cycle request to start a batch; sampled only in IDLE
- num_blocks  in  IDX_W  blocks in the batch; latched on accepted `run`
- me_start  out  1  to core `start`
- me_completed  in  1  core `completed` (level, held until start drops)
- me_best_dist  in  DIST_W  core BestDist
- me_motion_x  in  MV_W  core motionX
- me_motion_y  in  MV_W  core motionY
- block_idx  out  IDX_W  index of block in flight (drives frame loader)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  IDX_W+DIST_W+2*MV_W  {idx, dist, mx, my}, MSB first
- busy  out  1  batch in progress
- batch_done  out  1  one-cycle pulse when the batch ends
- stat_sum  out  16  BestDist sum (feature)
- stat_min  out  DIST_W  minimum BestDist (feature)

Behaviour:
- Reset values:
  - All outputs are 0; FIFO is empty; FSM is in IDLE.
  - Reset asserted mid-batch aborts immediately: `me_start` low, FIFO contents discarded.
- FSM states: IDLE, GAP, RUN, CAPT, DONE.
- IDLE:
  - `run` = 1: latch `num_blocks`, clear `block_idx`, assert `busy`.
  - If `num_blocks` = 0, go to DONE; otherwise go to GAP.
  - `run` in any other state is ignored.
- GAP:
  - `me_start` = 0 for GAP_CYC cycles.
  - Then go to RUN, but only if the FIFO is not full; otherwise hold in GAP until a pop frees an entry.
- RUN:
  - `me_start` = 1.
  - Stay until `me_completed` = 1, sampled at a clock edge.
  - `me_completed` high on the first RUN cycle (stale level from the previous run) is ignored. Capture is valid only on a cycle where `me_start` was already 1 in the previous cycle.
- CAPT (one cycle):
  - Push {block_idx, me_best_dist, me_motion_x, me_motion_y}.
  - `me_start` drops to 0.
  - If `block_idx` = latched count−1, go to DONE; otherwise increment `block_idx` and go to GAP.
- DONE (one cycle):
  - `batch_done` = 1 and `busy` → 0 next cycle; go to IDLE.
  - FIFO contents remain queued for draining.
- FIFO:
  - Show-ahead: `out_data` is valid whenever `out_valid` = 1.
  - Pop on `out_valid && out_ready`. Push and pop in the same cycle leave the count unchanged.
  - A push never occurs when full; the GAP stall guarantees this.
  - `out_data` is stable while `out_valid` && !`out_ready`.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Core `completed` edge to `out_valid` is 2 cycles (RUN sample → CAPT push → registered valid), when the FIFO was empty.

Optional Feature:
- Macro: ME_STATS_EN.
- Defined:
  - `stat_sum` accumulates `me_best_dist` on every CAPT, saturating at 16'hFFFF.
  - `stat_min` tracks the minimum BestDist.
  - Both clear on an accepted `run`; reset values are sum 0, min all-ones.
- Undefined: `stat_sum` and `stat_min` are tied to 0 and no accumulator registers exist.

Test Plan:
- `num_blocks`=1; core returns dist 8'h12, mx 4'h3, my 4'hE (−2), `out_ready`=1:
  - `me_start` high ≥1 cycle after 2 low cycles.
  - `out_data`=24'h00_12_3E two cycles after `completed`.
  - `batch_done` one pulse.
- `num_blocks`=6, `out_ready`=0:
  - After 4 captures `out_valid` stays 1 and the FSM holds in GAP with `me_start`=0.
  - Raising `out_ready` drains idx 0..5 in order with no loss or duplicate.
- `num_blocks`=0:
  - `batch_done` pulses within 2 cycles of `run`.
  - `me_start` never rises; FIFO stays empty.
- `run` re-pulsed during a batch of 3:
  - Ignored; exactly 3 results with idx 0,1,2.
- `reset_n` low while in RUN on block 2 of 4:
  - `me_start`, `busy`, `out_valid` go 0 asynchronously.
  - After release, a new `run` with count 1 yields idx 0.
- ME_STATS_EN defined, dists 200,100,250:
  - `stat_sum`=550, `stat_min`=100.
  - Without the macro both read 0.
